// File: rtl/parallel_to_serial_pkg.sv
// Shared serdes encodings.
// Bit-order values used by both converter directions.
package parallel_to_serial_pkg;
  localparam bit LSB_FIRST = 1'b0;
  localparam bit MSB_FIRST = 1'b1;
endpackage

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial converter with valid/ready on both sides.
// A one-word hold register lets the next word load mid-shift.
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int width     = 8,
  parameter bit msb_first = LSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  input  logic             serial_ready,
  output logic             serial_last,
  output logic             busy
);
  localparam int cnt_w = $clog2(width);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(width - 1);

  logic [width-1:0] a_q;
  logic [width-1:0] h_q;
  logic [width-1:0] a_shift;
  logic [cnt_w-1:0] cnt_q;
  logic             a_valid;
  logic             h_valid;
  logic             accept;
  logic             xfer;
  logic             last_xfer;
  logic             out_bit;

  assign accept    = parallel_valid && !h_valid;
  assign xfer      = a_valid && serial_ready;
  assign last_xfer = xfer && (cnt_q == cnt_max);

  always_comb begin
    a_shift = {1'b0, a_q[width-1:1]};
    out_bit = a_q[0];
    if (msb_first == MSB_FIRST) begin
      a_shift = {a_q[width-2:0], 1'b0};
      out_bit = a_q[width-1];
    end
  end

  // Outputs come from registered state only; no path from serial_ready.
  assign parallel_ready = !h_valid;
  assign serial_valid   = a_valid;
  assign serial_data    = a_valid && out_bit;
  assign serial_last    = a_valid && (cnt_q == cnt_max);
  assign busy           = a_valid || h_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      h_q     <= '0;
      cnt_q   <= '0;
      a_valid <= 1'b0;
      h_valid <= 1'b0;
    end else if (last_xfer) begin
      if (h_valid) begin
        a_q   <= h_q;
        cnt_q <= '0;
        if (accept) begin
          h_q <= parallel_data;
        end else begin
          h_valid <= 1'b0;
        end
      end else if (accept) begin
        a_q   <= parallel_data;
        cnt_q <= '0;
      end else begin
        a_valid <= 1'b0;
      end
    end else begin
      if (xfer) begin
        a_q   <= a_shift;
        cnt_q <= cnt_q + cnt_w'(1);
      end
      if (accept) begin
        if (!a_valid) begin
          a_q     <= parallel_data;
          a_valid <= 1'b1;
          cnt_q   <= '0;
        end else begin
          h_q     <= parallel_data;
          h_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Converts `width`-bit parallel words into a one-bit serial stream with a valid/ready handshake on both sides. It is the upstream partner of the serial-to-parallel converter. With the default bit order (LSB first), its `serial_valid`/`serial_data` outputs drive that converter directly, and the converter rebuilds the original word. A one-word holding register lets a new word be accepted while the current one is shifting out. With `serial_ready` held high, back-to-back words stream with no idle cycles.

## Interface
- `width`, default 8: parallel word size in bits; legal range is `width >= 2`.
- `msb_first`, default 0: bit order. 0 sends bit 0 first; 1 sends bit `width-1` first.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset. One clock; reset is asynchronous and active-high.
- `parallel_valid`  input  1  upstream word present.
- `parallel_data`  input  `width`  upstream word.
- `parallel_ready`  output  1  block can accept a word this cycle.
- `serial_valid`  output  1  `serial_data` holds a valid bit.
- `serial_data`  output  1  current serial bit.
- `serial_ready`  input  1  downstream takes the bit this cycle; tie to 1 when there is no backpressure.
- `serial_last`  output  1  current bit is the final bit of its word.
- `busy`  output  1  any word is in flight, either active or held.

## Operation
- **Internal state**
  - Active shift register `A` (`width` bits), bit counter `cnt` (`$clog2(width)` bits) and flag `a_valid`.
  - Holding register `H` (`width` bits) and flag `h_valid`.
- **Events**
  - Accept: `parallel_valid && parallel_ready`.
  - Transfer: `serial_valid && serial_ready`.
  - Last transfer: a transfer while `cnt == width-1`.
- **Outputs**
  - `parallel_ready = !h_valid`. It depends on registered state only, so there is no combinational path from `serial_ready`.
  - `serial_valid = a_valid`.
  - `serial_data` is `A[0]` when `msb_first = 0`, or `A[width-1]` when `msb_first = 1`. It is forced to 0 while `a_valid = 0`.
  - `serial_last = a_valid && cnt == width-1`.
  - `busy = a_valid || h_valid`.
- **Non-last transfer**
  - `A` shifts toward the output end (right for LSB-first, left for MSB-first), zero-filling.
  - `cnt` increments.
- **Last transfer**, in priority order:
  1. If `h_valid`: `A <= H` and `cnt <= 0`. If an accept also occurs this cycle, `H` takes the new word and `h_valid` stays 1; otherwise `h_valid <= 0`.
  2. Else if an accept occurs: `A` takes the new word directly and `cnt <= 0`.
  3. Else: `a_valid <= 0`.
- **Accept, no last transfer this cycle**
  - If `!a_valid`: `A` takes the new word, `a_valid <= 1`, `cnt <= 0`.
  - Otherwise: `H` takes the new word, `h_valid <= 1`.
- **Stalls**
  - `serial_ready = 0` freezes `A` and `cnt`.
  - An accept into `H` is still allowed during a stall.
- **Upstream rule**: upstream must hold `parallel_data` stable while `parallel_valid` is high and `parallel_ready` is low. The block samples data only on an accept.

## Timing
- **Reset values**
  - `serial_valid = 0`, `serial_data = 0`, `serial_last = 0`, `busy = 0`, `parallel_ready = 1`.
  - `A`, `H` and `cnt` are all 0.
- **Latency**
  - A word accepted at edge N drives its first bit, with `serial_valid = 1`, in the cycle after edge N.
  - With `serial_ready = 1` its last bit appears `width-1` cycles later.
- **Throughput**: one bit per cycle while `serial_ready = 1` and words are supplied. There is no gap between the last bit of word k and the first bit of word k+1.
- **Full**: with `a_valid` and `h_valid` both set, `parallel_ready = 0` until the cycle after the next last transfer.
- **Empty**: an accept while the block is idle loads `A` directly; `H` is not used.
- **Reset mid-word**: all in-flight bits are discarded. Outputs return to their reset values immediately (asynchronous), and no partial word resumes after reset.
- **Counter wrap**: for non-power-of-two `width`, `cnt` never exceeds `width-1`; it returns to 0 only on a reload.

## Structure
- Single module with no sub-modules. Active and hold registers are small enough to stay inline.
- No shared-package typedefs are required. Define `cnt_w = $clog2(width)` as a local constant.
- If a team-wide `serdes_pkg` exists, `msb_first` encodings may be shared from there.

## Test plan
- **Single word**: `width = 8`, LSB-first, `serial_ready = 1`, one accept of `8'hA5`.
  - Serial bits are 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - `serial_last` is high only on the 8th bit; `busy` falls the cycle after.
- **Back-to-back**: continuous `parallel_valid` with `8'h01`, `8'h80`, `8'hFF`.
  - 24 contiguous valid bits with no gap.
  - `parallel_ready` low while `H` is full.
- **Backpressure**: `serial_ready` toggled 1,0,0,1,…
  - Each bit is held for every stall cycle.
  - Decoded words match the input; a second word accepted into `H` during a stall is not lost.
- **MSB-first**: `msb_first = 1`, word `8'hC3`.
  - Bit order is 1,1,0,0,0,0,1,1.
- **Reset mid-word**: assert `rst` after 3 bits of `8'h5A`.
  - `serial_valid` drops immediately and `parallel_ready = 1`.
  - A next word `8'h3C` serializes cleanly from bit 0.
- **Loopback**: outputs feed the serial-to-parallel converter, `width = 8`, with 100 random words.
  - Every `parallel_valid` from the converter carries the original word, in order.
